// File: rtl/psr_cond_unit.sv
// Processor status register with masked ALU flag merge, LPR load, and a
// one-cycle-latency condition evaluator for Bcond/Jcond/Scond.
module psr_cond_unit #(
  parameter int WIDTH = 16,
  parameter int PSR_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PSR_W-1:0] alu_flags,
  input  logic             flag_we,
  input  logic [PSR_W-1:0] flag_mask,
  input  logic             psr_ld,
  input  logic [WIDTH-1:0] psr_wdata,
  input  logic             cond_req,
  input  logic [3:0]       cond,
  output logic [PSR_W-1:0] psr,
  output logic [WIDTH-1:0] psr_rdata,
  output logic             cond_valid,
  output logic             cond_true,
  output logic [WIDTH-1:0] scond_val
);

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
    CC_HI = 4'd4,  CC_LS = 4'd5,  CC_GT = 4'd6,  CC_LE = 4'd7,
    CC_FS = 4'd8,  CC_FC = 4'd9,  CC_LO = 4'd10, CC_HS = 4'd11,
    CC_LT = 4'd12, CC_GE = 4'd13, CC_UC = 4'd14, CC_NV = 4'd15
  } cond_e;

  localparam int N_BIT = 4;
  localparam int Z_BIT = 3;
  localparam int L_BIT = 2;
  localparam int F_BIT = 1;
  localparam int C_BIT = 0;

  logic [PSR_W-1:0] psr_next;
  logic             hit;
  logic             unused_wdata;

  assign unused_wdata = ^psr_wdata[WIDTH-1:PSR_W];

  // The value psr will take at this edge; conditions see it directly so a
  // compare and a branch can issue back to back.
  always_comb begin
    psr_next = psr;
    if (psr_ld)
      psr_next = psr_wdata[PSR_W-1:0];
    else if (flag_we)
      psr_next = (psr & ~flag_mask) | (alu_flags & flag_mask);
    psr_next[PSR_W-1] = 1'b0;
  end

  always_comb begin
    hit = 1'b0;
    case (cond_e'(cond))
      CC_EQ: hit =  psr_next[Z_BIT];
      CC_NE: hit = ~psr_next[Z_BIT];
      CC_CS: hit =  psr_next[C_BIT];
      CC_CC: hit = ~psr_next[C_BIT];
      CC_HI: hit =  psr_next[L_BIT];
      CC_LS: hit = ~psr_next[L_BIT];
      CC_GT: hit =  psr_next[N_BIT];
      CC_LE: hit = ~psr_next[N_BIT];
      CC_FS: hit =  psr_next[F_BIT];
      CC_FC: hit = ~psr_next[F_BIT];
      CC_LO: hit = ~psr_next[L_BIT] & ~psr_next[Z_BIT];
      CC_HS: hit =  psr_next[L_BIT] |  psr_next[Z_BIT];
      CC_LT: hit = ~psr_next[N_BIT] & ~psr_next[Z_BIT];
      CC_GE: hit =  psr_next[N_BIT] |  psr_next[Z_BIT];
      CC_UC: hit = 1'b1;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      psr        <= '0;
      cond_valid <= 1'b0;
      cond_true  <= 1'b0;
      scond_val  <= '0;
    end else begin
      psr        <= psr_next;
      cond_valid <= cond_req;
      if (cond_req) begin
        cond_true <= hit;
        scond_val <= {{(WIDTH-1){1'b0}}, hit};
      end
    end
  end

  assign psr_rdata = {{(WIDTH-PSR_W){1'b0}}, psr};

endmodule
